// File: rtl/add16_accumulator_pkg.sv
// Shared definitions for the frame accumulator: FSM encoding and adder width.
// Imported by the interface, the adder wrapper and the top.
package add16_accumulator_pkg;

  localparam int ADD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add16_accumulator_if.sv
// Frame request, word stream and result bus between a word source and the accumulator.
interface add16_accumulator_if
  import add16_accumulator_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int EXT_W = 8
);

  logic             start;
  logic [CNT_W-1:0] len;
  logic             valid;
  logic [ADD_W-1:0] data;
  logic             ready;
  logic [ADD_W-1:0] sum;
  logic [EXT_W-1:0] ext;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output start, len, valid, data,
    input  ready, sum, ext, ovf, busy, done
  );

  modport slave (
    input  start, len, valid, data,
    output ready, sum, ext, ovf, busy, done
  );

endinterface

// File: rtl/add16_accumulator_add16b.sv
// Plain 16-bit ripple adder, carry-in tied to 0; combinational.
module add16_accumulator_add16b
  import add16_accumulator_pkg::*;
(
  input  logic [ADD_W-1:0] a,
  input  logic [ADD_W-1:0] b,
  output logic [ADD_W-1:0] s,
  output logic             c
);

  assign {c, s} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/add16_accumulator.sv
// Frame accumulator: sums len words through the 16-bit adder, counting carry-outs in ext.
// Result valid the cycle after the last accept (with done); ready only while a frame runs.
module add16_accumulator
  import add16_accumulator_pkg::*;
#(
  parameter int WIDTH = ADD_W,
  parameter int CNT_W = 8,
  parameter int EXT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  add16_accumulator_if.slave   acc
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] rem;
  logic [WIDTH-1:0] sum;
  logic [EXT_W-1:0] ext;
  logic             ovf;
  logic             ready;
  logic             busy;
  logic             done;
  logic             accept;
  logic             last_word;
  logic [WIDTH-1:0] add_s;
  logic             add_c;

  add16_accumulator_add16b u_add (
    .a (sum),
    .b (acc.data),
    .s (add_s),
    .c (add_c)
  );

  assign accept    = acc.valid && ready;
  assign last_word = (rem == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (acc.start) begin
          state_nxt = (acc.len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        ready = 1'b1;
        busy  = 1'b1;
        if (accept && last_word) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A new frame clears the result; otherwise the last result is held for the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= '0;
      sum <= '0;
      ext <= '0;
      ovf <= 1'b0;
    end else if (state == ST_IDLE && acc.start) begin
      rem <= acc.len;
      sum <= '0;
      ext <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      rem <= rem - CNT_W'(1);
      sum <= add_s;
      if (add_c) begin
        ext <= ext + EXT_W'(1);
        if (&ext) begin
          ovf <= 1'b1;
        end
      end
    end
  end

  assign acc.ready = ready;
  assign acc.busy  = busy;
  assign acc.done  = done;
  assign acc.sum   = sum;
  assign acc.ext   = ext;
  assign acc.ovf   = ovf;

endmodule

// File: tb/tb_add16_accumulator.sv
// Directed bench: two accumulators (EXT_W=8 and EXT_W=2) driven in lockstep from one stimulus.
module tb_add16_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        valid = 1'b0;
  logic [15:0] data = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  add16_accumulator_if #(.CNT_W(8), .EXT_W(8)) bus8 ();
  add16_accumulator_if #(.CNT_W(8), .EXT_W(2)) bus2 ();

  assign bus8.start = start;
  assign bus8.len   = len;
  assign bus8.valid = valid;
  assign bus8.data  = data;
  assign bus2.start = start;
  assign bus2.len   = len;
  assign bus2.valid = valid;
  assign bus2.data  = data;

  add16_accumulator #(.CNT_W(8), .EXT_W(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .acc   (bus8.slave)
  );

  add16_accumulator #(.CNT_W(8), .EXT_W(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .acc   (bus2.slave)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic do_start(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Leaves valid high so consecutive calls stream back-to-back.
  task automatic send(input logic [15:0] d);
    int n = 0;
    valid = 1'b1;
    data  = d;
    while (!bus8.ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus8.ready) check("send_ready_timeout", {31'd0, bus8.ready}, 32'd1);
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    // reset state
    #2;
    check("rst_sum",   {16'd0, bus8.sum}, 32'd0);
    check("rst_ext",   {24'd0, bus8.ext}, 32'd0);
    check("rst_flags", {27'd0, bus8.ovf, bus8.ready, bus8.busy, bus8.done, bus2.ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: two-word sum with one carry
    do_start(8'd2);
    check("t1_busy", {31'd0, bus8.busy}, 32'd1);
    send(16'hF7F8);
    send(16'h7961);
    valid = 1'b0;
    check("t1_done", {31'd0, bus8.done}, 32'd1);
    check("t1_sum",  {16'd0, bus8.sum},  32'h7159);
    check("t1_ext",  {24'd0, bus8.ext},  32'd1);
    check("t1_ovf",  {31'd0, bus8.ovf},  32'd0);
    @(negedge clk);
    check("t1_done_pulse", {31'd0, bus8.done}, 32'd0);
    check("t1_sum_held",   {16'd0, bus8.sum},  32'h7159);

    // 2: zero-length frame
    do_start(8'd0);
    check("t2_done",  {31'd0, bus8.done},  32'd1);
    check("t2_ready", {31'd0, bus8.ready}, 32'd0);
    check("t2_sum",   {16'd0, bus8.sum},   32'd0);
    check("t2_ext",   {24'd0, bus8.ext},   32'd0);
    @(negedge clk);
    check("t2_after", {30'd0, bus8.ready, bus8.done}, 32'd0);

    // 3: valid in IDLE ignored, gaps between words
    valid = 1'b1;
    data  = 16'h0055;
    idle_cycles(3);
    check("t3_idle_ready", {31'd0, bus8.ready}, 32'd0);
    do_start(8'd3);
    send(16'h0001);
    valid = 1'b0;
    idle_cycles(2);
    check("t3_gap_busy", {31'd0, bus8.busy}, 32'd1);
    check("t3_gap_sum",  {16'd0, bus8.sum},  32'h0001);
    send(16'h0002);
    valid = 1'b0;
    idle_cycles(2);
    send(16'h0003);
    valid = 1'b0;
    check("t3_done", {31'd0, bus8.done}, 32'd1);
    check("t3_sum",  {16'd0, bus8.sum},  32'h0006);
    check("t3_ext",  {24'd0, bus8.ext},  32'd0);

    // 4: extension wrap on the EXT_W=2 instance
    @(negedge clk);
    do_start(8'd5);
    for (int i = 0; i < 5; i++) send(16'hFFFF);
    valid = 1'b0;
    check("t4_done",  {31'd0, bus2.done}, 32'd1);
    check("t4_sum2",  {16'd0, bus2.sum},  32'hFFFB);
    check("t4_ext2",  {30'd0, bus2.ext},  32'd0);
    check("t4_ovf2",  {31'd0, bus2.ovf},  32'd1);
    check("t4_ext8",  {24'd0, bus8.ext},  32'd4);
    check("t4_ovf8",  {31'd0, bus8.ovf},  32'd0);
    @(negedge clk);
    check("t4_ovf_held", {31'd0, bus2.ovf}, 32'd1);
    do_start(8'd1);
    check("t4_ovf_clr", {31'd0, bus2.ovf}, 32'd0);
    send(16'h0001);
    valid = 1'b0;
    @(negedge clk);

    // 5: asynchronous reset mid-frame
    do_start(8'd3);
    send(16'h0010);
    valid = 1'b0;
    check("t5_partial", {16'd0, bus8.sum}, 32'h0010);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_sum",   {16'd0, bus8.sum}, 32'd0);
    check("t5_rst_flags", {28'd0, bus8.ovf, bus8.ready, bus8.busy, bus8.done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_idle", {31'd0, bus8.busy}, 32'd0);
    do_start(8'd1);
    send(16'h0001);
    valid = 1'b0;
    check("t5_done", {31'd0, bus8.done}, 32'd1);
    check("t5_sum",  {16'd0, bus8.sum},  32'h0001);
    @(negedge clk);

    // 6: start while running is ignored
    do_start(8'd2);
    send(16'h0005);
    start = 1'b1;
    len   = 8'd7;
    data  = 16'h0006;
    @(negedge clk);
    start = 1'b0;
    valid = 1'b0;
    check("t6_done", {31'd0, bus8.done}, 32'd1);
    check("t6_sum",  {16'd0, bus8.sum},  32'h000B);
    @(negedge clk);
    check("t6_done_once", {31'd0, bus8.done}, 32'd0);
    check("t6_idle",      {31'd0, bus8.busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
